// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: req/ack handshake with data memory, upstream stall, MEM/WB register.
// Define MEM_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles and raise the sticky mem_err flag.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hlt,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [21:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_alu_result,
  input  logic        mem_alu_select,
  input  logic        mem_use_dst_reg,
  input  logic [4:0]  mem_dst_reg,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [21:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst_reg,
  output logic        wb_reg_we,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rdata_q;
  logic        launch;
  logic        in_wait;
  logic        ack_in_wait;
  logic        abort;

  if (TIMEOUT == 0 || TIMEOUT > 1023) begin : g_timeout_range
    $error("mem_access_ctrl: TIMEOUT must be in 1..1023");
  end

  // DONE never launches: the EX/MEM register still shows the access that just finished.
  assign launch      = (state == IDLE) && (mem_re || mem_we) && !hlt;
  assign in_wait     = (state == WAIT);
  assign ack_in_wait = in_wait && dm_ack;
  assign mem_stall   = launch || in_wait;

`ifdef MEM_TIMEOUT_EN
  logic [9:0] wait_cnt;

  // An ack arriving in the limit cycle takes priority over the abort.
  assign abort = in_wait && !dm_ack && (wait_cnt == 10'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (launch)
        wait_cnt <= '0;
      else if (in_wait && !dm_ack)
        wait_cnt <= wait_cnt + 10'd1;
      if (abort)
        mem_err <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  // NOTE: every always_ff uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = WAIT;
      WAIT:    if (ack_in_wait || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the async reset clears every datapath register, rdata_q included, so a reset mid-access
  // leaves no stale load data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req     <= 1'b0;
      dm_wr      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      rdata_q    <= '0;
      wb_data    <= '0;
      wb_dst_reg <= '0;
      wb_reg_we  <= 1'b0;
    end else begin
      if (launch) begin
        dm_req   <= 1'b1;
        dm_wr    <= mem_we;
        dm_addr  <= mem_addr;
        dm_wdata <= mem_wdata;
      end else if (ack_in_wait || abort) begin
        dm_req <= 1'b0;
      end

      if (ack_in_wait && !dm_wr)
        rdata_q <= dm_rdata;
      else if (abort)
        rdata_q <= '0;

      // Halt freezes the WB register completely; a stall only inserts a bubble.
      if (!hlt) begin
        if (mem_stall) begin
          wb_reg_we <= 1'b0;
        end else begin
          wb_data    <= mem_alu_select ? rdata_q : mem_alu_result;
          wb_dst_reg <= mem_dst_reg;
          wb_reg_we  <= mem_use_dst_reg;
        end
      end
    end
  end

endmodule
